// File: rtl/mmio_packet_pkg.sv
// Shared definitions for the MMIO packet bridge: register map, STATUS layout,
// packet-width helper and the byte-strobe merge used by every staging register.
// Latency/backpressure: n/a (definitions only).
package mmio_packet_pkg;

    // Register byte offsets inside the 256-byte window.
    localparam logic [7:0] OFF_TX_X       = 8'h00;
    localparam logic [7:0] OFF_TX_Y       = 8'h04;
    localparam logic [7:0] OFF_TX_PAYLOAD = 8'h08;
    localparam logic [7:0] OFF_TX_COMMIT  = 8'h40;
    localparam logic [7:0] OFF_STATUS     = 8'h44;
    localparam logic [7:0] OFF_RX_POP     = 8'h48;
    localparam logic [7:0] OFF_IRQ_EN     = 8'h4C;
    localparam logic [7:0] OFF_RX_X       = 8'h50;
    localparam logic [7:0] OFF_RX_Y       = 8'h54;
    localparam logic [7:0] OFF_RX_PAYLOAD = 8'h58;

    // STATUS bit positions.
    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_OVF       = 2;
    localparam int ST_RX_IRQ       = 3;
    localparam int ST_TX_COUNT_LSB = 8;
    localparam int ST_RX_COUNT_LSB = 16;

    // Packet = {x, y, payload[0], payload[1], ...}; payload word 0 is most significant.
    function automatic int pkt_width(input int coord_bits, input int payload_words);
        return 2 * coord_bits + 32 * payload_words;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/packet_fifo.sv
// Generic packet FIFO, power-of-2 depth; head is visible combinationally from registered state.
// Latency: a pushed entry reaches the head on the cycle after the push edge.
// Backpressure: push accepted when not full, or when full with a same-edge pop; pop on empty is ignored.
// Ports: clk/reset, push/push_dat, pop, head_dat, full, empty, count.
module packet_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mmio_packet_bridge.sv
// Memory-mapped bridge between a CPU look-ahead bus and a packet network (TX and RX FIFOs).
// Latency: register reads 1 cycle; committed packet visible on pkt_out the cycle after commit.
// Backpressure: pkt_out held while !pkt_out_ready; pkt_in_ready drops only when RX is full with no pop.
// Ports: clk, reset, mem_la_* CPU access, bus_rdata/bus_hit read return,
//        pkt_out/_valid/_ready transmit, pkt_in/_valid/_ready receive, irq level interrupt.
module mmio_packet_bridge
    import mmio_packet_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0100,
    parameter int          COORD_BITS    = 1,
    parameter int          PAYLOAD_WORDS = 2,
    parameter int          TX_DEPTH      = 4,
    parameter int          RX_DEPTH      = 4,
    parameter int          IRQ_THRESHOLD = 1,
    localparam int         P             = pkt_width(COORD_BITS, PAYLOAD_WORDS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_la_read,
    input  logic         mem_la_write,
    input  logic [31:0]  mem_la_addr,
    input  logic [31:0]  mem_la_wdata,
    input  logic [3:0]   mem_la_wstrb,
    output logic [31:0]  bus_rdata,
    output logic         bus_hit,
    output logic [P-1:0] pkt_out,
    output logic         pkt_out_valid,
    input  logic         pkt_out_ready,
    input  logic [P-1:0] pkt_in,
    input  logic         pkt_in_valid,
    output logic         pkt_in_ready,
    output logic         irq
);
    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;

    logic                  in_win;
    logic [7:0]            off;
    logic                  wr_en;
    logic                  tx_commit;
    logic                  rx_pop;
    logic                  ovf_clr;
    logic [COORD_BITS-1:0] tx_x;
    logic [COORD_BITS-1:0] tx_y;
    logic [31:0]           tx_pl [PAYLOAD_WORDS];
    logic [31:0]           x_merged;
    logic [31:0]           y_merged;
    logic                  irq_en;
    logic                  tx_ovf;
    logic [P-1:0]          tx_pkt;
    logic [P-1:0]          tx_head;
    logic [P-1:0]          rx_head;
    logic [P-1:0]          rx_view;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [TCW-1:0]        tx_count;
    logic [RCW-1:0]        rx_count;
    logic [31:0]           status;
    logic [31:0]           rd_val;

    assign in_win    = (mem_la_addr[31:8] == BASE_ADDR[31:8]);
    assign off       = mem_la_addr[7:0];
    assign wr_en     = mem_la_write && in_win;
    assign tx_commit = wr_en && (off == OFF_TX_COMMIT) && (|mem_la_wstrb);
    assign rx_pop    = wr_en && (off == OFF_RX_POP);
    assign ovf_clr   = wr_en && (off == OFF_STATUS) && mem_la_wstrb[0] && mem_la_wdata[ST_TX_OVF];
    assign x_merged  = merge_bytes(32'(tx_x), mem_la_wdata, mem_la_wstrb);
    assign y_merged  = merge_bytes(32'(tx_y), mem_la_wdata, mem_la_wstrb);

    always_comb begin
        tx_pkt = '0;
        tx_pkt[P-1 -: COORD_BITS]            = tx_x;
        tx_pkt[P-1-COORD_BITS -: COORD_BITS] = tx_y;
        for (int k = 0; k < PAYLOAD_WORDS; k++) begin
            tx_pkt[32*(PAYLOAD_WORDS-k)-1 -: 32] = tx_pl[k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_x   <= '0;
            tx_y   <= '0;
            irq_en <= 1'b0;
            tx_ovf <= 1'b0;
            for (int k = 0; k < PAYLOAD_WORDS; k++) tx_pl[k] <= '0;
        end else begin
            if (wr_en && off == OFF_TX_X) tx_x <= x_merged[COORD_BITS-1:0];
            if (wr_en && off == OFF_TX_Y) tx_y <= y_merged[COORD_BITS-1:0];
            for (int k = 0; k < PAYLOAD_WORDS; k++) begin
                if (wr_en && off == OFF_TX_PAYLOAD + 8'(4*k))
                    tx_pl[k] <= merge_bytes(tx_pl[k], mem_la_wdata, mem_la_wstrb);
            end
            if (wr_en && off == OFF_IRQ_EN && mem_la_wstrb[0]) irq_en <= mem_la_wdata[0];
            // Full FIFO drops the commit unless the head departs on this edge; set beats clear.
            if (tx_commit && tx_full && !pkt_out_ready) tx_ovf <= 1'b1;
            else if (ovf_clr)                           tx_ovf <= 1'b0;
        end
    end

    packet_fifo #(.WIDTH(P), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tx_commit),
        .push_dat (tx_pkt),
        .pop      (pkt_out_ready),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .count    (tx_count)
    );

    assign pkt_out_valid = !tx_empty;
    assign pkt_out       = tx_empty ? '0 : tx_head;

    // A pop in the same cycle frees a slot, so a full RX can still accept.
    assign pkt_in_ready = !rx_full || rx_pop;

    packet_fifo #(.WIDTH(P), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (pkt_in_valid && pkt_in_ready),
        .push_dat (pkt_in),
        .pop      (rx_pop),
        .head_dat (rx_head),
        .full     (rx_full),
        .empty    (rx_empty),
        .count    (rx_count)
    );

    assign rx_view = rx_empty ? '0 : rx_head;

    always_comb begin
        status = '0;
        status[ST_TX_NOT_FULL]            = !tx_full;
        status[ST_RX_NOT_EMPTY]           = !rx_empty;
        status[ST_TX_OVF]                 = tx_ovf;
        status[ST_RX_IRQ]                 = irq;
        status[ST_TX_COUNT_LSB +: 8]      = 8'(tx_count);
        status[ST_RX_COUNT_LSB +: 8]      = 8'(rx_count);
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_TX_X:   rd_val = 32'(tx_x);
            OFF_TX_Y:   rd_val = 32'(tx_y);
            OFF_STATUS: rd_val = status;
            OFF_IRQ_EN: rd_val = {31'b0, irq_en};
            OFF_RX_X:   rd_val = 32'(rx_view[P-1 -: COORD_BITS]);
            OFF_RX_Y:   rd_val = 32'(rx_view[P-1-COORD_BITS -: COORD_BITS]);
            default:    rd_val = '0;
        endcase
        for (int k = 0; k < PAYLOAD_WORDS; k++) begin
            if (off == OFF_TX_PAYLOAD + 8'(4*k)) rd_val = tx_pl[k];
            if (off == OFF_RX_PAYLOAD + 8'(4*k)) rd_val = rx_view[32*(PAYLOAD_WORDS-k)-1 -: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_rdata <= '0;
            bus_hit   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            bus_hit   <= (mem_la_read || mem_la_write) && in_win;
            bus_rdata <= (mem_la_read && in_win) ? rd_val : '0;
            irq       <= irq_en && (int'(rx_count) >= IRQ_THRESHOLD);
        end
    end

endmodule

// File: tb/tb_mmio_packet_bridge.sv
// Self-checking bench for mmio_packet_bridge: directed scenarios plus randomized
// traffic, checked against a queue-based model of the register/packet behaviour.
module tb_mmio_packet_bridge;
    localparam logic [31:0] BASE = 32'h1000_0100;
    localparam int CB  = 1;
    localparam int PW  = 2;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int THR = 1;
    localparam int P   = 2*CB + 32*PW;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mem_la_read = 1'b0;
    logic         mem_la_write = 1'b0;
    logic [31:0]  mem_la_addr = '0;
    logic [31:0]  mem_la_wdata = '0;
    logic [3:0]   mem_la_wstrb = '0;
    logic [31:0]  bus_rdata;
    logic         bus_hit;
    logic [P-1:0] pkt_out;
    logic         pkt_out_valid;
    logic         pkt_out_ready = 1'b0;
    logic [P-1:0] pkt_in = '0;
    logic         pkt_in_valid = 1'b0;
    logic         pkt_in_ready;
    logic         irq;

    mmio_packet_bridge #(
        .BASE_ADDR(BASE), .COORD_BITS(CB), .PAYLOAD_WORDS(PW),
        .TX_DEPTH(TXD), .RX_DEPTH(RXD), .IRQ_THRESHOLD(THR)
    ) dut (
        .clk(clk), .reset(reset),
        .mem_la_read(mem_la_read), .mem_la_write(mem_la_write),
        .mem_la_addr(mem_la_addr), .mem_la_wdata(mem_la_wdata), .mem_la_wstrb(mem_la_wstrb),
        .bus_rdata(bus_rdata), .bus_hit(bus_hit),
        .pkt_out(pkt_out), .pkt_out_valid(pkt_out_valid), .pkt_out_ready(pkt_out_ready),
        .pkt_in(pkt_in), .pkt_in_valid(pkt_in_valid), .pkt_in_ready(pkt_in_ready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [P-1:0] txq[$];
    logic [P-1:0] rxq[$];
    logic [31:0]  m_x, m_y;
    logic [31:0]  m_pl [PW];
    bit           m_ovf, m_irq_en, m_irq, m_rx_acc;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [P-1:0] rnd_pkt();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[P-1:0];
    endfunction

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_x = 0; m_y = 0; m_pl[0] = 0; m_pl[1] = 0;
        m_ovf = 0; m_irq_en = 0; m_irq = 0; m_rx_acc = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] off);
        logic [P-1:0] h;
        h = (rxq.size() > 0) ? rxq[0] : '0;
        case (off)
            8'h00: return {31'b0, m_x[0]};
            8'h04: return {31'b0, m_y[0]};
            8'h08: return m_pl[0];
            8'h0C: return m_pl[1];
            8'h44: return {8'h0, 8'(rxq.size()), 8'(txq.size()), 4'h0,
                           m_irq, m_ovf, rxq.size() > 0, txq.size() < TXD};
            8'h4C: return {31'b0, m_irq_en};
            8'h50: return {31'b0, h[P-1]};
            8'h54: return {31'b0, h[P-2]};
            8'h58: return h[63:32];
            8'h5C: return h[31:0];
            default: return 32'h0;
        endcase
    endfunction

    // One clock cycle with the currently driven inputs; checks outputs before and after the edge.
    task automatic step();
        bit in_win, wr, rd, pop_wr, tx_pop, rx_pop, rx_push, nxt_irq, exp_hit;
        logic [7:0]  off;
        logic [31:0] exp_rd;
        #1;
        in_win = (mem_la_addr[31:8] == BASE[31:8]);
        off    = mem_la_addr[7:0];
        wr     = mem_la_write && in_win;
        rd     = mem_la_read && in_win;
        pop_wr = wr && off == 8'h48;
        chk("pkt_out_valid", pkt_out_valid, txq.size() > 0);
        if (txq.size() > 0) chk("pkt_out", pkt_out, txq[0]);
        chk("pkt_in_ready", pkt_in_ready, (rxq.size() < RXD) || pop_wr);
        exp_hit = (mem_la_read || mem_la_write) && in_win;
        exp_rd  = rd ? model_read(off) : 32'h0;
        nxt_irq = m_irq_en && rxq.size() >= THR;
        tx_pop  = pkt_out_ready && txq.size() > 0;
        rx_pop  = pop_wr && rxq.size() > 0;
        rx_push = pkt_in_valid && ((rxq.size() < RXD) || pop_wr);
        if (tx_pop) void'(txq.pop_front());
        if (wr && off == 8'h40 && mem_la_wstrb != 0) begin
            if (txq.size() < TXD) txq.push_back({m_x[0], m_y[0], m_pl[0], m_pl[1]});
            else m_ovf = 1;
        end
        if (wr && off == 8'h44 && mem_la_wstrb[0] && mem_la_wdata[2]) m_ovf = 0;
        if (wr && off == 8'h00) m_x = merge(m_x, mem_la_wdata, mem_la_wstrb) & 32'h1;
        if (wr && off == 8'h04) m_y = merge(m_y, mem_la_wdata, mem_la_wstrb) & 32'h1;
        if (wr && off == 8'h08) m_pl[0] = merge(m_pl[0], mem_la_wdata, mem_la_wstrb);
        if (wr && off == 8'h0C) m_pl[1] = merge(m_pl[1], mem_la_wdata, mem_la_wstrb);
        if (wr && off == 8'h4C && mem_la_wstrb[0]) m_irq_en = mem_la_wdata[0];
        if (rx_pop) void'(rxq.pop_front());
        if (rx_push) rxq.push_back(pkt_in);
        m_rx_acc = rx_push;
        @(posedge clk);
        #1;
        m_irq = nxt_irq;
        chk("bus_hit", bus_hit, exp_hit);
        chk("bus_rdata", bus_rdata, exp_rd);
        chk("irq", irq, m_irq);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] strb);
        mem_la_write = 1; mem_la_addr = BASE + off; mem_la_wdata = data; mem_la_wstrb = strb;
        step();
        mem_la_write = 0; mem_la_wstrb = 0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] data);
        mem_la_read = 1; mem_la_addr = BASE + off;
        step();
        mem_la_read = 0;
        data = bus_rdata;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0]  d;
        logic [P-1:0] exp4[$];
        logic [P-1:0] pk [5];
        int n;

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", bus_rdata, 0);
        chk("rst_hit", bus_hit, 0);
        chk("rst_out_valid", pkt_out_valid, 0);
        chk("rst_in_ready", pkt_in_ready, 1);
        chk("rst_irq", irq, 0);
        reset = 0;

        // Single packet, ready high.
        pkt_out_ready = 1;
        wr(32'h00, 32'h1, 4'hF);
        wr(32'h04, 32'h0, 4'hF);
        wr(32'h08, 32'hDEADBEEF, 4'hF);
        wr(32'h0C, 32'h12345678, 4'hF);
        wr(32'h40, 32'h1, 4'hF);
        chk("r026_valid", pkt_out_valid, 1);
        chk("r026_pkt", pkt_out, {1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678});
        step();
        rd(32'h44, d);
        chk("r026_txcount", d[15:8], 0);

        // Byte strobes and window boundaries.
        wr(32'h08, 32'h0, 4'hF);
        wr(32'h08, 32'h0000AB00, 4'b0010);
        rd(32'h08, d);
        chk("r030_strobe1", d, 32'h0000AB00);
        wr(32'h08, 32'h00CDCD00, 4'b0100);
        rd(32'h08, d);
        chk("r030_strobe2", d, 32'h00CDAB00);
        rd(32'h100, d);
        chk("r030_miss_hit", bus_hit, 0);
        chk("r030_miss_rdata", d, 0);
        wr(32'h140, 32'h1, 4'hF);
        chk("r030_miss_nocommit", pkt_out_valid, 0);

        // Overflow with ready low, clear, then drain in order.
        pkt_out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            wr(32'h08, $urandom, 4'hF);
            wr(32'h40, 32'h1, 4'hF);
        end
        rd(32'h44, d);
        chk("r027_txcount", d[15:8], 4);
        chk("r027_ovf", d[2], 1);
        chk("r027_not_full", d[0], 0);
        wr(32'h44, 32'h4, 4'h1);
        rd(32'h44, d);
        chk("r027_ovf_clr", d[2], 0);
        exp4 = txq;
        pkt_out_ready = 1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            if (pkt_out_valid) begin
                if (n < 4) chk("r027_order", pkt_out, exp4[n]);
                n++;
            end
            step();
        end
        chk("r027_count", n, 4);

        // Commit into a full FIFO while the head leaves on the same edge.
        pkt_out_ready = 0;
        for (int i = 0; i < 4; i++) wr(32'h40, 32'h1, 4'hF);
        pkt_out_ready = 1;
        wr(32'h40, 32'h1, 4'hF);
        rd(32'h44, d);
        chk("bypass_txcount", d[15:8], 4);
        chk("bypass_ovf", d[2], 0);
        repeat (6) step();

        // Randomized TX traffic.
        for (int c = 0; c < 200; c++) begin
            pkt_out_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin mem_la_write = 1; mem_la_addr = BASE + 32'h40; mem_la_wstrb = 4'hF; end
                1: begin
                    mem_la_write = 1;
                    mem_la_addr  = BASE + 4 * $urandom_range(0, 3);
                    if ($urandom_range(0, 4) == 0) mem_la_addr = BASE + 32'h44;
                    mem_la_wdata = $urandom;
                    mem_la_wstrb = 4'($urandom_range(0, 15));
                end
                2: begin mem_la_read = 1; mem_la_addr = BASE + 4 * $urandom_range(0, 31); end
                default: ;
            endcase
            step();
            mem_la_write = 0; mem_la_read = 0; mem_la_wstrb = 0;
        end
        pkt_out_ready = 1;
        repeat (6) step();
        wr(32'h44, 32'h4, 4'h1);

        // RX fills, full back-pressure, pop-in-same-cycle acceptance.
        for (int i = 0; i < 4; i++) begin
            pk[i] = rnd_pkt();
            pkt_in_valid = 1; pkt_in = pk[i];
            step();
        end
        pk[4] = rnd_pkt();
        pkt_in = pk[4];
        #1;
        chk("r028_ready_full", pkt_in_ready, 0);
        mem_la_write = 1; mem_la_addr = BASE + 32'h48; mem_la_wstrb = 4'hF; mem_la_wdata = 0;
        #1;
        chk("r028_ready_pop", pkt_in_ready, 1);
        step();
        pkt_in_valid = 0; mem_la_write = 0; mem_la_wstrb = 0;
        rd(32'h44, d);
        chk("r028_rxcount", d[23:16], 4);
        rd(32'h58, d);
        chk("r028_head", d, pk[1][63:32]);
        for (int i = 0; i < 4; i++) begin
            rd(32'h50, d); rd(32'h54, d); rd(32'h58, d); rd(32'h5C, d);
            wr(32'h48, 32'h0, 4'hF);
        end

        // Interrupt timing.
        wr(32'h4C, 32'h1, 4'hF);
        pkt_in_valid = 1; pkt_in = rnd_pkt();
        step();
        pkt_in_valid = 0;
        chk("r029_irq_1cyc", irq, 0);
        step();
        chk("r029_irq_2cyc", irq, 1);
        wr(32'h48, 32'h0, 4'hF);
        step();
        chk("r029_irq_clear", irq, 0);
        wr(32'h48, 32'h0, 4'hF);
        rd(32'h44, d);
        chk("r029_empty_pop_status", d, 32'h0000_0001);
        rd(32'h50, d);
        chk("r029_empty_rx_x", d, 0);

        // Randomized RX traffic with holding of un-accepted packets.
        for (int c = 0; c < 150; c++) begin
            if (!pkt_in_valid) begin
                pkt_in_valid = 1'($urandom_range(0, 1));
                pkt_in = rnd_pkt();
            end
            case ($urandom_range(0, 3))
                0: begin mem_la_write = 1; mem_la_addr = BASE + 32'h48; mem_la_wstrb = 4'hF; end
                1: begin
                    mem_la_read = 1;
                    mem_la_addr = BASE + 32'h50 + 4 * $urandom_range(0, 3);
                    if ($urandom_range(0, 3) == 0) mem_la_addr = BASE + 32'h44;
                end
                default: ;
            endcase
            step();
            mem_la_write = 0; mem_la_read = 0; mem_la_wstrb = 0;
            if (m_rx_acc) pkt_in_valid = 0;
        end
        pkt_in_valid = 0;
        repeat (5) wr(32'h48, 32'h0, 4'hF);

        // Reset in the middle of a transmit.
        pkt_out_ready = 0;
        wr(32'h00, 32'h1, 4'hF);
        wr(32'h40, 32'h1, 4'hF);
        chk("rst_pre_valid", pkt_out_valid, 1);
        #2;
        reset = 1;
        #1;
        chk("rst_mid_valid", pkt_out_valid, 0);
        chk("rst_mid_in_ready", pkt_in_ready, 1);
        chk("rst_mid_irq", irq, 0);
        model_reset();
        reset = 0;
        rd(32'h00, d);
        chk("rst_tx_x", d, 0);
        rd(32'h44, d);
        chk("rst_status", d, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
